// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer and the exception detector.
package trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_W_MTVAL,
        ST_W_MSTATUS,
        ST_W_MSTATUS_RET,
        ST_REDIRECT
    } trap_state_t;

    typedef enum logic {
        KIND_TRAP,
        KIND_MRET
    } trap_kind_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LSB  = 11;
    localparam int MIE_MTIE_BIT     = 7;

    localparam logic [31:0] CAUSE_MISALIGNED_FETCH = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL_INSN     = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT       = 32'd3;
    localparam logic [31:0] CAUSE_MISALIGNED_LOAD  = 32'd4;
    localparam logic [31:0] CAUSE_MISALIGNED_STORE = 32'd6;
    localparam logic [31:0] CAUSE_ECALL_M          = 32'd11;

    function automatic logic [31:0] mstatusOnTrap(input logic [31:0] snap);
        logic [31:0] result;
        result = snap;
        result[MSTATUS_MPIE_BIT] = snap[MSTATUS_MIE_BIT];
        result[MSTATUS_MIE_BIT]  = 1'b0;
        result[MSTATUS_MPP_LSB +: 2] = 2'b11;
        return result;
    endfunction

    function automatic logic [31:0] mstatusOnMret(input logic [31:0] snap);
        logic [31:0] result;
        result = snap;
        result[MSTATUS_MIE_BIT]  = snap[MSTATUS_MPIE_BIT];
        result[MSTATUS_MPIE_BIT] = 1'b1;
        result[MSTATUS_MPP_LSB +: 2] = 2'b11;
        return result;
    endfunction

endpackage

// File: rtl/trap_irq_sync.sv
// Flop chain bringing the asynchronous machine-timer pending line into the core clock domain.
module trap_irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap controller: accepts exception/interrupt/MRET, sequences CSR writes, then redirects.
// Optional macro TRAP_VECTORED_MODE_EN enables vectored interrupt targets when mtvec[1:0]==2'b01.
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int          MTIP_SYNC_STAGES = 2,
    parameter logic [31:0] IRQ_CAUSE        = 32'h8000_0007
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_present_i,
    input  logic [31:0] exc_cause_i,
    input  logic [31:0] trap_info_i,
    input  logic [31:0] pc_i,
    input  logic        inst_boundary_i,
    input  logic        mret_i,
    input  logic        mtip_i,
    input  logic [31:0] csr_mstatus_i,
    input  logic [31:0] csr_mie_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    output logic        csr_wr_valid_o,
    input  logic        csr_wr_ready_i,
    output logic [11:0] csr_wr_addr_o,
    output logic [31:0] csr_wr_data_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    trap_state_t state_q, state_d;
    trap_kind_t  kind_q, kind_d;
    logic        irq_q, irq_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] mstatus_q, mstatus_d;
    logic        mtipSync;
    logic        irqTake;
    logic [31:0] trapTarget;
    logic        unusedBits;

    trap_irq_sync #(.STAGES(MTIP_SYNC_STAGES)) u_irq_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (mtip_i),
        .sync_o  (mtipSync)
    );

    assign irqTake    = mtipSync & csr_mstatus_i[MSTATUS_MIE_BIT] & csr_mie_i[MIE_MTIE_BIT];
    assign unusedBits = ^{csr_mie_i[31:8], csr_mie_i[6:0], csr_mtvec_i[1:0], csr_mepc_i[1:0]};

    always_comb begin
        trapTarget = {csr_mtvec_i[31:2], 2'b00};
`ifdef TRAP_VECTORED_MODE_EN
        if (irq_q && (csr_mtvec_i[1:0] == 2'b01)) begin
            trapTarget = {csr_mtvec_i[31:2], 2'b00} + {cause_q[29:0], 2'b00};
        end
`endif
    end

    // Acceptance is gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        irq_d            = irq_q;
        epc_d            = epc_q;
        cause_d          = cause_q;
        tval_d           = tval_q;
        mstatus_d        = mstatus_q;
        csr_wr_valid_o   = 1'b0;
        csr_wr_addr_o    = '0;
        csr_wr_data_o    = '0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        busy_o           = (state_q != ST_IDLE);
        stall_o          = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (rst_n && inst_boundary_i && (exc_present_i || irqTake || mret_i)) begin
                    busy_o    = 1'b1;
                    stall_o   = 1'b1;
                    flush_o   = 1'b1;
                    epc_d     = pc_i;
                    mstatus_d = csr_mstatus_i;
                    if (exc_present_i) begin
                        kind_d  = KIND_TRAP;
                        irq_d   = 1'b0;
                        cause_d = exc_cause_i;
                        tval_d  = trap_info_i;
                        state_d = ST_W_MEPC;
                    end else if (irqTake) begin
                        kind_d  = KIND_TRAP;
                        irq_d   = 1'b1;
                        cause_d = IRQ_CAUSE;
                        tval_d  = '0;
                        state_d = ST_W_MEPC;
                    end else begin
                        kind_d  = KIND_MRET;
                        irq_d   = 1'b0;
                        state_d = ST_W_MSTATUS_RET;
                    end
                end
            end
            ST_W_MEPC: begin
                csr_wr_valid_o = 1'b1;
                csr_wr_addr_o  = CSR_MEPC;
                csr_wr_data_o  = epc_q;
                if (csr_wr_ready_i) state_d = ST_W_MCAUSE;
            end
            ST_W_MCAUSE: begin
                csr_wr_valid_o = 1'b1;
                csr_wr_addr_o  = CSR_MCAUSE;
                csr_wr_data_o  = cause_q;
                if (csr_wr_ready_i) state_d = ST_W_MTVAL;
            end
            ST_W_MTVAL: begin
                csr_wr_valid_o = 1'b1;
                csr_wr_addr_o  = CSR_MTVAL;
                csr_wr_data_o  = tval_q;
                if (csr_wr_ready_i) state_d = ST_W_MSTATUS;
            end
            ST_W_MSTATUS: begin
                csr_wr_valid_o = 1'b1;
                csr_wr_addr_o  = CSR_MSTATUS;
                csr_wr_data_o  = mstatusOnTrap(mstatus_q);
                if (csr_wr_ready_i) state_d = ST_REDIRECT;
            end
            ST_W_MSTATUS_RET: begin
                csr_wr_valid_o = 1'b1;
                csr_wr_addr_o  = CSR_MSTATUS;
                csr_wr_data_o  = mstatusOnMret(mstatus_q);
                if (csr_wr_ready_i) state_d = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_valid_o = 1'b1;
                flush_o          = 1'b1;
                redirect_pc_o    = (kind_q == KIND_MRET) ? {csr_mepc_i[31:2], 2'b00} : trapTarget;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            kind_q    <= KIND_TRAP;
            irq_q     <= 1'b0;
            epc_q     <= '0;
            cause_q   <= '0;
            tval_q    <= '0;
            mstatus_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            irq_q     <= irq_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            tval_q    <= tval_d;
            mstatus_q <= mstatus_d;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed table, randomized events against a reference model, reset abort.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_present_i, inst_boundary_i, mret_i, mtip_i, csr_wr_ready_i;
    logic [31:0] exc_cause_i, trap_info_i, pc_i;
    logic [31:0] csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i;
    logic        csr_wr_valid_o, stall_o, flush_o, redirect_valid_o, busy_o;
    logic [11:0] csr_wr_addr_o;
    logic [31:0] csr_wr_data_o, redirect_pc_o;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        exc;
        logic [31:0] cause;
        logic [31:0] tval;
        logic [31:0] pc;
        logic        mret;
        logic        mtip;
        logic [31:0] mstatus;
        logic [31:0] mie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        int          stallIdx;
        int          stallCnt;
        int          expCycle;
        logic [31:0] expPc;
        logic [31:0] expMstatusWr;
    } vec_t;

    vec_t vecTable[8];

    logic [11:0] modelAddr[$];
    logic [31:0] modelData[$];
    logic        modelTaken;
    logic [31:0] modelPc;
    int          modelCycle;

    trap_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exc_present_i    (exc_present_i),
        .exc_cause_i      (exc_cause_i),
        .trap_info_i      (trap_info_i),
        .pc_i             (pc_i),
        .inst_boundary_i  (inst_boundary_i),
        .mret_i           (mret_i),
        .mtip_i           (mtip_i),
        .csr_mstatus_i    (csr_mstatus_i),
        .csr_mie_i        (csr_mie_i),
        .csr_mtvec_i      (csr_mtvec_i),
        .csr_mepc_i       (csr_mepc_i),
        .csr_wr_valid_o   (csr_wr_valid_o),
        .csr_wr_ready_i   (csr_wr_ready_i),
        .csr_wr_addr_o    (csr_wr_addr_o),
        .csr_wr_data_o    (csr_wr_data_o),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Architectural view: which event wins, the CSR writes it implies, where the PC goes and when.
    function automatic void buildModel(input vec_t v);
        logic        irqPending, isIrq;
        logic [31:0] cause, tval, base;
        modelAddr.delete();
        modelData.delete();
        irqPending = v.mtip && v.mstatus[3] && v.mie[7];
        modelTaken = v.exc || irqPending || v.mret;
        modelPc    = 32'h0;
        modelCycle = 0;
        if (!modelTaken) return;
        if (v.exc || irqPending) begin
            isIrq = !v.exc;
            cause = isIrq ? 32'h8000_0007 : v.cause;
            tval  = isIrq ? 32'h0 : v.tval;
            modelAddr.push_back(12'h341); modelData.push_back(v.pc);
            modelAddr.push_back(12'h342); modelData.push_back(cause);
            modelAddr.push_back(12'h343); modelData.push_back(tval);
            modelAddr.push_back(12'h300);
            modelData.push_back((v.mstatus & ~32'h1888) | (v.mstatus[3] ? 32'h80 : 32'h0) | 32'h1800);
            base    = v.mtvec & ~32'h3;
            modelPc = base;
`ifdef TRAP_VECTORED_MODE_EN
            if (isIrq && v.mtvec[1:0] == 2'b01) modelPc = base + 4 * (cause & 32'h7FFF_FFFF);
`endif
        end else begin
            modelAddr.push_back(12'h300);
            modelData.push_back((v.mstatus & ~32'h1888) | (v.mstatus[7] ? 32'h8 : 32'h0) | 32'h1880);
            modelPc = v.mepc & ~32'h3;
        end
        modelCycle = 1;
        for (int k = 0; k < modelAddr.size(); k++) begin
            modelCycle += 1 + ((k == v.stallIdx) ? v.stallCnt : 0);
        end
    endfunction

    task automatic driveIdle(input vec_t v);
        inst_boundary_i = 1'b0;
        exc_present_i   = 1'b0;
        mret_i          = 1'b0;
        mtip_i          = v.mtip;
        csr_mstatus_i   = v.mstatus;
        csr_mie_i       = v.mie;
        csr_mtvec_i     = v.mtvec;
        csr_mepc_i      = v.mepc;
        csr_wr_ready_i  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Presents one event at an instruction boundary, then follows the sequence with
    // random noise on the event inputs, which must be ignored while busy.
    task automatic applyStimulus(input vec_t v, input int id);
        int   wrIdx, stallLeft, cyc;
        logic done;
        driveIdle(v);
        checkOutput($sformatf("v%0d idleBusy", id), {31'b0, busy_o}, 32'h0);
        buildModel(v);
        inst_boundary_i = 1'b1;
        exc_present_i   = v.exc;
        exc_cause_i     = v.cause;
        trap_info_i     = v.tval;
        pc_i            = v.pc;
        mret_i          = v.mret;
        #1;
        checkOutput($sformatf("v%0d acceptStall", id), {31'b0, stall_o}, {31'b0, modelTaken});
        checkOutput($sformatf("v%0d acceptFlush", id), {31'b0, flush_o}, {31'b0, modelTaken});
        @(posedge clk); #1;
        inst_boundary_i = 1'b0;
        exc_present_i   = 1'b0;
        mret_i          = 1'b0;
        if (!modelTaken) begin
            checkOutput($sformatf("v%0d noEventBusy", id), {31'b0, busy_o}, 32'h0);
            return;
        end
        wrIdx = 0; stallLeft = v.stallCnt; cyc = 1; done = 1'b0;
        while (!done && cyc < 80) begin
            checkOutput($sformatf("v%0d c%0d busy", id, cyc), {31'b0, busy_o}, 32'h1);
            if (csr_wr_valid_o) begin
                if (wrIdx < modelAddr.size()) begin
                    checkOutput($sformatf("v%0d w%0d addr", id, wrIdx), {20'b0, csr_wr_addr_o}, {20'b0, modelAddr[wrIdx]});
                    checkOutput($sformatf("v%0d w%0d data", id, wrIdx), csr_wr_data_o,
                                (wrIdx == modelAddr.size() - 1) ? v.expMstatusWr : modelData[wrIdx]);
                end else begin
                    checkOutput($sformatf("v%0d extraWrite", id), {20'b0, csr_wr_addr_o}, 32'hFFFF_FFFF);
                end
                if (wrIdx == v.stallIdx && stallLeft > 0) begin
                    csr_wr_ready_i = 1'b0;
                    stallLeft--;
                end else begin
                    csr_wr_ready_i = 1'b1;
                    wrIdx++;
                end
            end else begin
                csr_wr_ready_i = 1'($urandom_range(0, 1));
            end
            if (redirect_valid_o) begin
                checkOutput($sformatf("v%0d redirectPc", id), redirect_pc_o, v.expPc);
                checkOutput($sformatf("v%0d redirectCycle", id), cyc, v.expCycle);
                checkOutput($sformatf("v%0d redirectFlush", id), {31'b0, flush_o}, 32'h1);
                inst_boundary_i = 1'b0;
                exc_present_i   = 1'b0;
                mret_i          = 1'b0;
                done = 1'b1;
            end else begin
                checkOutput($sformatf("v%0d c%0d flushLow", id, cyc), {31'b0, flush_o}, 32'h0);
                inst_boundary_i = 1'($urandom_range(0, 1));
                exc_present_i   = 1'($urandom_range(0, 1));
                mret_i          = 1'($urandom_range(0, 1));
                pc_i            = $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) checkOutput($sformatf("v%0d redirectTimeout", id), 32'h0, 32'h1);
        checkOutput($sformatf("v%0d writeCount", id), wrIdx, modelAddr.size());
        checkOutput($sformatf("v%0d idleAfter", id), {31'b0, busy_o}, 32'h0);
        checkOutput($sformatf("v%0d validAfter", id), {31'b0, csr_wr_valid_o}, 32'h0);
    endtask

    task automatic resetAbortTest();
        vec_t v;
        int   cyc, validSeen;
        logic found;
        v = vecTable[0];
        driveIdle(v);
        inst_boundary_i = 1'b1;
        exc_present_i   = 1'b1;
        exc_cause_i     = v.cause;
        trap_info_i     = v.tval;
        pc_i            = v.pc;
        @(posedge clk); #1;
        inst_boundary_i = 1'b0;
        exc_present_i   = 1'b0;
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 20) begin
            if (csr_wr_valid_o && csr_wr_addr_o == 12'h343) found = 1'b1;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        checkOutput("rst reachMtval", {31'b0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst valid", {31'b0, csr_wr_valid_o}, 32'h0);
        checkOutput("rst addr", {20'b0, csr_wr_addr_o}, 32'h0);
        checkOutput("rst data", csr_wr_data_o, 32'h0);
        checkOutput("rst stall", {31'b0, stall_o}, 32'h0);
        checkOutput("rst busy", {31'b0, busy_o}, 32'h0);
        checkOutput("rst redirect", {31'b0, redirect_valid_o}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        validSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (csr_wr_valid_o || busy_o) validSeen++;
        end
        checkOutput("rst noResume", validSeen, 0);
    endtask

    initial begin
        vec_t rv;
        vecTable[0] = '{1'b1, 32'd2, 32'h13, 32'h400, 1'b0, 1'b0, 32'h8, 32'h0, 32'h200, 32'h0, 0, 0, 5, 32'h200, 32'h1880};
        vecTable[1] = '{1'b1, 32'd2, 32'h13, 32'h400, 1'b0, 1'b0, 32'h8, 32'h0, 32'h200, 32'h0, 1, 3, 8, 32'h200, 32'h1880};
`ifdef TRAP_VECTORED_MODE_EN
        vecTable[2] = '{1'b0, 32'd0, 32'h0, 32'h500, 1'b0, 1'b1, 32'h8, 32'h80, 32'h101, 32'h0, 0, 0, 5, 32'h11C, 32'h1880};
`else
        vecTable[2] = '{1'b0, 32'd0, 32'h0, 32'h500, 1'b0, 1'b1, 32'h8, 32'h80, 32'h101, 32'h0, 0, 0, 5, 32'h100, 32'h1880};
`endif
        vecTable[3] = '{1'b1, 32'd11, 32'h0, 32'h600, 1'b0, 1'b1, 32'h8, 32'h80, 32'h101, 32'h0, 2, 1, 6, 32'h100, 32'h1880};
        vecTable[4] = '{1'b0, 32'd0, 32'h0, 32'h604, 1'b1, 1'b1, 32'h1880, 32'h80, 32'h100, 32'h403, 0, 0, 2, 32'h400, 32'h1888};
        vecTable[5] = '{1'b0, 32'd0, 32'h0, 32'h404, 1'b0, 1'b1, 32'h1888, 32'h80, 32'h100, 32'h403, 0, 2, 7, 32'h100, 32'h1880};
        vecTable[6] = '{1'b0, 32'd0, 32'h0, 32'h700, 1'b0, 1'b0, 32'h8, 32'h80, 32'h100, 32'h0, 0, 0, 0, 32'h0, 32'h0};
        vecTable[7] = '{1'b0, 32'd0, 32'h0, 32'h704, 1'b0, 1'b1, 32'h0, 32'h80, 32'h100, 32'h0, 0, 0, 0, 32'h0, 32'h0};

        rst_n = 1'b0;
        exc_present_i = 1'b0; inst_boundary_i = 1'b0; mret_i = 1'b0; mtip_i = 1'b0;
        csr_wr_ready_i = 1'b1;
        exc_cause_i = '0; trap_info_i = '0; pc_i = '0;
        csr_mstatus_i = '0; csr_mie_i = '0; csr_mtvec_i = '0; csr_mepc_i = '0;
        #12;
        checkOutput("reset busy", {31'b0, busy_o}, 32'h0);
        checkOutput("reset stall", {31'b0, stall_o}, 32'h0);
        checkOutput("reset valid", {31'b0, csr_wr_valid_o}, 32'h0);
        checkOutput("reset redirectPc", redirect_pc_o, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 8; i++) applyStimulus(vecTable[i], i);

        for (int i = 0; i < 24; i++) begin
            rv.exc      = ($urandom_range(0, 2) == 0);
            rv.cause    = $urandom_range(0, 15);
            rv.tval     = $urandom;
            rv.pc       = $urandom & 32'hFFFF_FFFC;
            rv.mret     = ($urandom_range(0, 2) == 0);
            rv.mtip     = 1'($urandom_range(0, 1));
            rv.mstatus  = $urandom;
            rv.mie      = $urandom;
            rv.mtvec    = $urandom;
            rv.mepc     = $urandom;
            rv.stallIdx = $urandom_range(0, 3);
            rv.stallCnt = $urandom_range(0, 3);
            buildModel(rv);
            rv.expCycle     = modelCycle;
            rv.expPc        = modelPc;
            rv.expMstatusWr = modelTaken ? modelData[modelData.size() - 1] : 32'h0;
            applyStimulus(rv, 100 + i);
        end

        resetAbortTest();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap controller sitting between the exception detector, the CSR file and PC-select logic of the RV32I core.
- On a detected exception, timer interrupt or MRET, it stalls the core and sequences the required CSR writes (mepc, mcause, mtval, mstatus) through the single CSR write port using a valid/ready handshake.
- It then issues a one-cycle PC redirect and flush.
- Exception > interrupt > MRET priority is resolved here.

Parameters:
- MTIP_SYNC_STAGES, 2, flop stages synchronising the asynchronous mtip_i (1..3 legal).
- IRQ_CAUSE, 32'h8000_0007, mcause value written for the machine timer interrupt.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- exc_present_i  in  1  exception flagged for the current instruction
- exc_cause_i  in  32  mcause value for the exception
- trap_info_i  in  32  mtval value for the exception
- pc_i  in  32  PC of the current instruction
- inst_boundary_i  in  1  current instruction may be trapped/interrupted this cycle
- mret_i  in  1  current instruction is a valid MRET
- mtip_i  in  1  machine timer pending, asynchronous
- csr_mstatus_i  in  32  current mstatus
- csr_mie_i  in  32  current mie
- csr_mtvec_i  in  32  current mtvec
- csr_mepc_i  in  32  current mepc
- csr_wr_valid_o  out  1  CSR write request
- csr_wr_ready_i  in  1  CSR file accepts the write
- csr_wr_addr_o  out  12  CSR address
- csr_wr_data_o  out  32  CSR write data
- stall_o  out  1  freeze fetch/execute
- flush_o  out  1  squash in-flight instruction
- redirect_valid_o  out  1  load redirect_pc_o into PC
- redirect_pc_o  out  32  new PC
- busy_o  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; FSM to IDLE; capture registers and synchroniser to 0.
- Reset mid-sequence: abandon immediately, no resumption, no further CSR writes.
- Events are sampled only in IDLE with inst_boundary_i=1.
- Priority: exc_present_i > irq_take > mret_i.
  - irq_take = mtip_sync & mstatus[3] (MIE) & mie[7] (MTIE).
  - Lower-priority events in the same cycle are dropped. Interrupt stays pending and is re-evaluated after return.
- Capture on acceptance:
  - epc = pc_i.
  - cause = exc_cause_i, or IRQ_CAUSE for an interrupt.
  - tval = trap_info_i, or 0 for an interrupt.
  - mstatus snapshot, kind (TRAP/MRET).
- Trap path: W_MEPC -> W_MCAUSE -> W_MTVAL -> W_MSTATUS -> REDIRECT -> IDLE.
  - CSR addresses 341/342/343/300.
  - mstatus data = snapshot with MPIE(7) = MIE, MIE(3) = 0, MPP(12:11) = 2'b11.
- MRET path: W_MSTATUS_RET -> REDIRECT -> IDLE.
  - mstatus data = snapshot with MIE = MPIE, MPIE = 1, MPP = 2'b11.
- Handshake on each W_ state:
  - csr_wr_valid_o=1 with addr/data stable until the cycle csr_wr_ready_i=1.
  - Advance on that edge; valid may not drop before ready.
  - Unbounded wait.
- REDIRECT: redirect_valid_o=1 and flush_o=1 for exactly one cycle.
  - Trap: redirect_pc_o = {csr_mtvec_i[31:2], 2'b00}.
  - MRET: redirect_pc_o = {csr_mepc_i[31:2], 2'b00}, with mepc read in REDIRECT.
- Other outputs:
  - stall_o = busy_o = (state != IDLE), plus the acceptance cycle combinationally.
  - flush_o also pulses in the acceptance cycle.
- Latency with ready tied high:
  - Trap: accept at T0, redirect at T5, IDLE at T6.
  - MRET: accept at T0, redirect at T2.
- Events during busy are ignored; the core is stalled.
- Exception raised by the trap handler's first instruction is accepted normally (no nesting check).

Optional Feature:
- Macro TRAP_VECTORED_MODE_EN.
- Defined: when mtvec[1:0]==2'b01 and the trap is an interrupt, redirect_pc_o = base + 4*cause[30:0]. Exceptions and mode 00 still use base.
- Undefined: mtvec[1:0] is ignored and every trap goes to base.

Decomposition:
- Package trap_pkg:
  - trap_state_t enum.
  - CSR_MSTATUS/MEPC/MCAUSE/MTVAL address constants.
  - MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7, MSTATUS_MPP_LSB=11.
  - MIE_MTIE_BIT=7.
  - Cause codes shared with the exception detector.
- Sub-module trap_irq_sync: MTIP_SYNC_STAGES-deep flop chain on mtip_i, reset to 0.

Test Plan:
- exc_present_i=1, cause=2, tval=0x13, pc=0x400, ready=1, mstatus=0x8 -> writes 341=0x400, 342=2, 343=0x13, 300=0x1880 in order; redirect_pc=mtvec base at T5.
- Same trap with ready low 3 cycles on the mcause write -> valid/addr/data held constant; sequence completes at T8.
- mtip_i=1, MIE=1, MTIE=1, pc=0x500 -> mcause=0x80000007, mtval=0. With TRAP_VECTORED_MODE_EN and mtvec=0x101: redirect=0x11C.
- exc_present_i and irq_take in the same cycle -> exception cause written; after MRET the interrupt is taken.
- mret_i, mstatus=0x1880, mepc=0x403 -> 300=0x1888 written; redirect_pc=0x400 at T2.
- rst_n low during W_MTVAL -> all outputs 0 asynchronously, no mstatus write; IDLE after release.
